// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART transmit line between
// NREQ byte-stream requesters. The owner keeps the line for a whole message
// (until it hands over a byte flagged last), so messages never interleave.
// A lock timeout releases an owner that stalls mid-message.
module uart_tx_arbiter #(
  parameter int NREQ         = 3,
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              uart_tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam int PW  = $clog2(NREQ);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);
  localparam logic [31:0]   TMO_LAST = 32'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            lock;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   rr_ptr;
  logic [7:0]      shreg;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_idx;
  logic [31:0]     tmo_cnt;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   acc_idx;
  logic [7:0]      acc_byte;
  logic            accept;
  logic            bit_end;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  // Round-robin winner: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int p;
    p         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    // Walk from the far end so the closest candidate to rr_ptr is the last write.
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= NREQ) p = p - NREQ;
      if (req_valid[PW'(p)]) begin
        win_found = 1'b1;
        win_idx   = PW'(p);
      end
    end
  end

  // Ready only in IDLE: locked owner unconditionally, else the arbitration winner.
  always_comb begin
    req_ready = '0;
    if (resetn && state == IDLE) begin
      if (lock)           req_ready = onehot(owner);
      else if (win_found) req_ready = onehot(win_idx);
    end
  end

  assign acc_idx = lock ? owner : win_idx;
  assign accept  = |(req_valid & req_ready);
  assign bit_end = (div_cnt == DIV_LAST);

  // Select the byte of the accepted requester with constant part-selects.
  always_comb begin
    acc_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_idx == PW'(i)) acc_byte = req_data[8*i +: 8];
    end
  end

  // Control path: arbitration, lock/timeout, baud divider and line state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      lock    <= 1'b0;
      owner   <= '0;
      rr_ptr  <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
      tmo_cnt <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= acc_idx;
            lock    <= ~req_last[acc_idx];
            if (req_last[acc_idx]) rr_ptr <= next_idx(acc_idx);
            tmo_cnt <= '0;
            div_cnt <= '0;
            grant   <= onehot(acc_idx);
            busy    <= 1'b1;
            uart_tx <= 1'b0;
            state   <= START;
          end else if (lock && LOCK_TIMEOUT != 0) begin
            // No accept while locked means the owner is not offering a byte.
            if (tmo_cnt == TMO_LAST) begin
              lock    <= 1'b0;
              rr_ptr  <= next_idx(owner);
              tmo_cnt <= '0;
              grant   <= '0;
              busy    <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shreg shifts on this same edge, so bit 1 becomes the next LSB.
              uart_tx <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= IDLE;
            busy    <= lock;
            if (!lock) grant <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: load the accepted byte, shift right at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (accept) shreg <= acc_byte;
    else if (state == DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Divider and timeout are scaled down
// (DIV = 5, LOCK_TIMEOUT = 20) so every scenario runs in a few thousand cycles;
// a second instance with LOCK_TIMEOUT = 0 shares the same stimulus.
module tb_uart_tx_arbiter;

  localparam int DIV   = 5;
  localparam int LT    = 20;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready, grant;
  logic        busy, uart_tx;
  logic [2:0]  ready_nt, grant_nt;
  logic        busy_nt, tx_nt;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] rx_q[$];

  uart_tx_arbiter #(.NREQ(3), .CLK_FREQ(500), .BAUD(100), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .uart_tx(uart_tx));

  uart_tx_arbiter #(.NREQ(3), .CLK_FREQ(500), .BAUD(100), .LOCK_TIMEOUT(0)) dut_nt (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_nt), .grant(grant_nt), .busy(busy_nt),
    .uart_tx(tx_nt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent 8N1 receiver on dut.uart_tx, sampling mid-bit at negedges.
  initial begin : rx_decoder
    logic [7:0] v;
    logic abort;
    int n;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_tx === 1'b0) begin
        abort = 1'b0;
        v = '0;
        for (int k = 0; k < 9; k++) begin
          if (!abort) begin
            n = (k == 0) ? DIV + DIV / 2 : DIV;
            for (int j = 0; j < n; j++) begin
              if (!abort) begin
                @(negedge clk);
                if (resetn !== 1'b1) abort = 1'b1;
              end
            end
            if (!abort && k < 8) v[k] = uart_tx;
            if (!abort && k == 8 && uart_tx === 1'b1) rx_q.push_back(v);
          end
        end
      end
    end
  end

  function automatic logic [7:0] rx_at(int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 3'b000;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2 * FRAME && !ok; c++) begin
      if (busy === 1'b0) ok = 1'b1;
      else step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 3'b111;
    req_data = 24'h323130;
    req_last = 3'b111;
    step();
    step();
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
    n_total++; if (tx_nt !== 1'b1) $display("FAIL reset_tx_nt: got %b want 1", tx_nt); else n_pass++;
    req_valid = 3'b000;
    resetn = 1'b1;
    step();
    n_total++; if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL post_reset_idle: got grant=%b busy=%b want 000/0", grant, busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic exp_tx;
    logic [2:0] exp_g;
    b = 8'h55;
    rx_q.delete();
    req_data = {8'h00, 8'h00, b};
    req_last = 3'b001;
    req_valid = 3'b001;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL single_ready: got %b want 001", req_ready); else n_pass++;
    step();
    req_valid = 3'b000;
    for (int k = 0; k <= FRAME; k++) begin
      if (k < DIV) exp_tx = 1'b0;
      else if (k < 9 * DIV) exp_tx = b[(k - DIV) / DIV];
      else exp_tx = 1'b1;
      exp_g = (k < FRAME) ? 3'b001 : 3'b000;
      n_total++; if (uart_tx !== exp_tx) $display("FAIL single_tx k=%0d: got %b want %b", k, uart_tx, exp_tx); else n_pass++;
      n_total++; if (grant !== exp_g) $display("FAIL single_grant k=%0d: got %b want %b", k, grant, exp_g); else n_pass++;
      n_total++; if (busy !== (k < FRAME)) $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k < FRAME)); else n_pass++;
      if (k < FRAME) step();
    end
    n_total++; if (rx_q.size() != 1 || rx_at(0) !== 8'h55) $display("FAIL single_rx: got n=%0d b=%h want n=1 b=55", rx_q.size(), rx_at(0)); else n_pass++;
  endtask

  task automatic test_message_lock();
    logic [2:0] acc;
    logic [2:0] ids[3];
    int edges[3];
    int nacc;
    logic early;
    bit ok;
    nacc = 0;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin ids[i] = 3'b000; edges[i] = -1000; end
    rx_q.delete();
    req_data = {8'h00, 8'h41, 8'h5A};
    req_last = 3'b001;
    req_valid = 3'b011;
    #1;
    for (int c = 0; c < 4 * (FRAME + 1) && nacc < 3; c++) begin
      acc = req_valid & req_ready;
      if (nacc < 2 && req_ready[0]) early = 1'b1;
      step();
      if (acc != 3'b000) begin
        ids[nacc] = acc;
        edges[nacc] = cyc;
        nacc++;
        if (acc == 3'b010 && nacc == 1) begin
          req_data[15:8] = 8'h42;
          req_last[1] = 1'b1;
        end else if (acc == 3'b010) begin
          req_valid[1] = 1'b0;
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      #1;
    end
    n_total++; if (nacc != 3) $display("FAIL lock_accepts: got %0d want 3", nacc); else n_pass++;
    n_total++; if (ids[0] !== 3'b010 || ids[1] !== 3'b010 || ids[2] !== 3'b001) $display("FAIL lock_order: got %b %b %b want 010 010 001", ids[0], ids[1], ids[2]); else n_pass++;
    n_total++; if (edges[1] - edges[0] != FRAME + 1) $display("FAIL lock_gap1: got %0d want %0d", edges[1] - edges[0], FRAME + 1); else n_pass++;
    n_total++; if (edges[2] - edges[1] != FRAME + 1) $display("FAIL lock_gap2: got %0d want %0d", edges[2] - edges[1], FRAME + 1); else n_pass++;
    n_total++; if (early !== 1'b0) $display("FAIL lock_ready0_early: got %b want 0", early); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL lock_idle_timeout: got busy=%b want 0", busy); else n_pass++;
    n_total++; if (rx_q.size() != 3 || rx_at(0) !== 8'h41 || rx_at(1) !== 8'h42 || rx_at(2) !== 8'h5A)
      $display("FAIL lock_rx: got n=%0d %h %h %h want 41 42 5a", rx_q.size(), rx_at(0), rx_at(1), rx_at(2)); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] acc;
    logic [2:0] ids[4];
    logic [2:0] exp_ids[4];
    int edges[4];
    int nacc;
    bit ok;
    exp_ids = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 4; i++) begin ids[i] = 3'b000; edges[i] = -1000; end
    nacc = 0;
    apply_reset();
    rx_q.delete();
    req_data = 24'h323130;
    req_last = 3'b111;
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 5 * (FRAME + 1) && nacc < 4; c++) begin
      acc = req_valid & req_ready;
      step();
      if (acc != 3'b000) begin
        ids[nacc] = acc;
        edges[nacc] = cyc;
        nacc++;
      end
      #1;
    end
    req_valid = 3'b000;
    n_total++; if (nacc != 4) $display("FAIL rr_accepts: got %0d want 4", nacc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (ids[i] !== exp_ids[i]) $display("FAIL rr_order[%0d]: got %b want %b", i, ids[i], exp_ids[i]); else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_total++; if (edges[i] - edges[i-1] != FRAME + 1) $display("FAIL rr_gap[%0d]: got %0d want %0d", i, edges[i] - edges[i-1], FRAME + 1); else n_pass++;
    end
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL rr_idle_timeout: got busy=%b want 0", busy); else n_pass++;
    n_total++; if (rx_q.size() != 4 || rx_at(0) !== 8'h30 || rx_at(1) !== 8'h31 || rx_at(2) !== 8'h32 || rx_at(3) !== 8'h30)
      $display("FAIL rr_rx: got n=%0d %h %h %h %h want 30 31 32 30", rx_q.size(), rx_at(0), rx_at(1), rx_at(2), rx_at(3)); else n_pass++;
  endtask

  task automatic test_lock_timeout();
    logic held_bad;
    logic nt_served;
    held_bad = 1'b0;
    nt_served = 1'b0;
    req_data = {8'h77, 8'h00, 8'h30};
    req_last = 3'b001;
    req_valid = 3'b100;
    #1;
    n_total++; if (req_ready !== 3'b100) $display("FAIL tmo_first_ready: got %b want 100", req_ready); else n_pass++;
    step();
    req_valid = 3'b001;
    for (int k = 1; k <= FRAME + LT + 1; k++) begin
      step();
      if (k < FRAME + LT) begin
        if (grant !== 3'b100 || grant_nt !== 3'b100 || req_ready[0] !== 1'b0) held_bad = 1'b1;
      end
      if (k == FRAME) begin
        n_total++; if (busy !== 1'b1) $display("FAIL tmo_busy_locked: got %b want 1", busy); else n_pass++;
      end
      if (k == FRAME + LT) begin
        n_total++; if (grant !== 3'b000) $display("FAIL tmo_release_grant: got %b want 000", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL tmo_release_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (req_ready !== 3'b001) $display("FAIL tmo_release_ready: got %b want 001", req_ready); else n_pass++;
        n_total++; if (grant_nt !== 3'b100) $display("FAIL notmo_grant: got %b want 100", grant_nt); else n_pass++;
      end
      if (k == FRAME + LT + 1) begin
        n_total++; if (grant !== 3'b001 || uart_tx !== 1'b0) $display("FAIL tmo_req0_accept: got grant=%b tx=%b want 001/0", grant, uart_tx); else n_pass++;
      end
    end
    n_total++; if (held_bad !== 1'b0) $display("FAIL tmo_hold: got %b want 0", held_bad); else n_pass++;
    for (int c = 0; c < 1000; c++) begin
      if (grant_nt !== 3'b100 || ready_nt[0] !== 1'b0 || busy_nt !== 1'b1) nt_served = 1'b1;
      step();
    end
    n_total++; if (nt_served !== 1'b0) $display("FAIL notmo_never_served: got %b want 0", nt_served); else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    apply_reset();
    rx_q.delete();
    req_data = {8'h00, 8'h3C, 8'h00};
    req_last = 3'b010;
    req_valid = 3'b010;
    #1;
    n_total++; if (req_ready !== 3'b010) $display("FAIL mid_first_ready: got %b want 010", req_ready); else n_pass++;
    step();
    repeat (4 * DIV + 2) step();
    resetn = 1'b0;
    step();
    n_total++; if (uart_tx !== 1'b1) $display("FAIL mid_tx: got %b want 1", uart_tx); else n_pass++;
    n_total++; if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL mid_grant_busy: got %b/%b want 000/0", grant, busy); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL mid_ready_in_reset: got %b want 000", req_ready); else n_pass++;
    step();
    resetn = 1'b1;
    #1;
    n_total++; if (req_ready !== 3'b010) $display("FAIL mid_ready_after: got %b want 010", req_ready); else n_pass++;
    step();
    req_valid = 3'b000;
    n_total++; if (grant !== 3'b010 || busy !== 1'b1 || uart_tx !== 1'b0) $display("FAIL mid_reaccept: got %b/%b/%b want 010/1/0", grant, busy, uart_tx); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL mid_idle_timeout: got busy=%b want 0", busy); else n_pass++;
    n_total++; if (rx_q.size() != 1 || rx_at(0) !== 8'h3C) $display("FAIL mid_rx: got n=%0d %h want 3c", rx_q.size(), rx_at(0)); else n_pass++;
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = 3'b000;
    req_data = '0;
    req_last = 3'b000;
    test_reset();
    test_single();
    test_message_lock();
    test_round_robin();
    test_lock_timeout();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
